// File: rtl/el2_ccm_banked_mem.sv
// Multi-channel, multi-bank CCM front end with per-bank round-robin arbitration.
// Optional define EL2_CCM_RD_PIPE_EN adds a response register stage (2-cycle read latency).
module el2_ccm_banked_mem #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 39,
  parameter int BANK_LSB  = 2,
  parameter int ROW_W     = ADDR_W - BANK_LSB - $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_req_valid,
  output logic [NUM_CH-1:0]           ch_req_ready,
  input  logic [NUM_CH-1:0]           ch_req_wr,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0]    ch_req_wdata,
  output logic [NUM_CH-1:0]           ch_rsp_valid,
  output logic [NUM_CH*DATA_W-1:0]    ch_rsp_rdata,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic [NUM_BANKS-1:0]        bank_wen,
  output logic [NUM_BANKS*ROW_W-1:0]  bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic [15:0]                 conflict_cnt
);

  localparam int          CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          BK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned NCH  = NUM_CH;

  logic [BK_W-1:0]   ch_bank  [NUM_CH];
  logic [ROW_W-1:0]  ch_row   [NUM_CH];
  logic [DATA_W-1:0] ch_wdata [NUM_CH];

  logic [CH_W-1:0]      rr_ptr_q [NUM_BANKS];
  logic [CH_W-1:0]      rr_ptr_d [NUM_BANKS];
  logic [CH_W-1:0]      win      [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_gnt;
  logic [NUM_CH-1:0]    ch_gnt;

  logic [NUM_CH-1:0]        rd_pend_q, rd_pend_d;
  logic [BK_W-1:0]          bsel_q [NUM_CH];
  logic [BK_W-1:0]          bsel_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rsp_rdata_c;

  logic [15:0] cnt_q, cnt_d;

  // Low (byte-offset) address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^ch_req_addr;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_bank[c]  = (NUM_BANKS > 1) ? ch_req_addr[c*ADDR_W + BANK_LSB +: BK_W] : '0;
      ch_row[c]   = ch_req_addr[c*ADDR_W + ADDR_W - ROW_W +: ROW_W];
      ch_wdata[c] = ch_req_wdata[c*DATA_W +: DATA_W];
    end
  end

  // Search from the pointer upward with wrap; first valid requester for this bank wins.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_gnt[b] = 1'b0;
      win[b]      = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = rr_ptr_q[b] + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!bank_gnt[b] && ch_req_valid[idx] && (ch_bank[idx] == BK_W'(b))) begin
          bank_gnt[b] = 1'b1;
          win[b]      = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ch_gnt = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) ch_gnt[win[b]] = 1'b1;
    end
  end

  assign ch_req_ready = ch_gnt;

  always_comb begin
    int unsigned nxt;
    nxt = 0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      rr_ptr_d[b] = rr_ptr_q[b];
      if (bank_gnt[b]) begin
        nxt = win[b] + 1;
        if (nxt >= NCH) nxt = 0;
        rr_ptr_d[b] = CH_W'(nxt);
      end
    end
  end

  always_comb begin
    bank_en    = '0;
    bank_wen   = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) begin
        bank_en[b]                      = 1'b1;
        bank_wen[b]                     = ch_req_wr[win[b]];
        bank_addr[b*ROW_W +: ROW_W]     = ch_row[win[b]];
        bank_wdata[b*DATA_W +: DATA_W]  = ch_wdata[win[b]];
      end
    end
  end

  always_comb begin
    rd_pend_d = ch_gnt & ~ch_req_wr;
    for (int unsigned c = 0; c < NCH; c++) begin
      bsel_d[c] = rd_pend_d[c] ? ch_bank[c] : bsel_q[c];
    end
  end

  always_comb begin
    rsp_rdata_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rd_pend_q[c])
        rsp_rdata_c[c*DATA_W +: DATA_W] = bank_rdata[int'(bsel_q[c])*DATA_W +: DATA_W];
    end
  end

`ifdef EL2_CCM_RD_PIPE_EN
  logic [NUM_CH-1:0]        rsp_valid_q;
  logic [NUM_CH*DATA_W-1:0] rsp_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_pend_q;
      rsp_rdata_q <= rsp_rdata_c;
    end
  end

  assign ch_rsp_valid = rsp_valid_q;
  assign ch_rsp_rdata = rsp_rdata_q;
`else
  assign ch_rsp_valid = rd_pend_q;
  assign ch_rsp_rdata = rsp_rdata_c;
`endif

  // Every valid-but-not-ready channel is one lost arbitration cycle.
  always_comb begin
    logic [NUM_CH-1:0] lost;
    logic [4:0]        n;
    logic [16:0]       sum;
    lost = ch_req_valid & ~ch_gnt;
    n    = '0;
    for (int unsigned c = 0; c < NCH; c++) n = n + 5'(lost[c]);
    sum   = 17'(cnt_q) + 17'(n);
    cnt_d = sum[16] ? '1 : sum[15:0];
  end

  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= '0;
      for (int unsigned c = 0; c < NCH; c++) bsel_q[c] <= '0;
      rd_pend_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= rr_ptr_d[b];
      for (int unsigned c = 0; c < NCH; c++) bsel_q[c] <= bsel_d[c];
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_el2_ccm_banked_mem.sv
// Scoreboard bench for el2_ccm_banked_mem: directed stimulus, queued read expectations, negedge monitor.
module tb_el2_ccm_banked_mem;

  localparam int NCH = 2;
  localparam int NB  = 4;
  localparam int AW  = 16;
  localparam int DW  = 39;
  localparam int RW  = 12;
`ifdef EL2_CCM_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    ch_req_valid = '0;
  logic [NCH-1:0]    ch_req_ready;
  logic [NCH-1:0]    ch_req_wr = '0;
  logic [NCH*AW-1:0] ch_req_addr = '0;
  logic [NCH*DW-1:0] ch_req_wdata = '0;
  logic [NCH-1:0]    ch_rsp_valid;
  logic [NCH*DW-1:0] ch_rsp_rdata;
  logic [NB-1:0]     bank_en;
  logic [NB-1:0]     bank_wen;
  logic [NB*RW-1:0]  bank_addr;
  logic [NB*DW-1:0]  bank_wdata;
  logic [NB*DW-1:0]  bank_rdata;
  logic [15:0]       conflict_cnt;

  el2_ccm_banked_mem #(.NUM_CH(NCH), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .BANK_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_wr(ch_req_wr),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_rdata(ch_rsp_rdata),
    .bank_en(bank_en), .bank_wen(bank_wen), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, a few rows preloaded while reset is held.
  logic [DW-1:0] mem [NB][1<<RW];
  logic [DW-1:0] rdata_q [NB];
  always @(posedge clk) begin
    if (rst) begin
      mem[1][2] <= 39'h12345;
      mem[0][4] <= 39'h0AAAA;
      mem[2][0] <= 39'h00100;
      mem[2][1] <= 39'h00201;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_en[b]) begin
          if (bank_wen[b]) mem[b][bank_addr[b*RW +: RW]] <= bank_wdata[b*DW +: DW];
          else             rdata_q[b] <= mem[b][bank_addr[b*RW +: RW]];
        end
      end
    end
  end
  assign bank_rdata = {rdata_q[3], rdata_q[2], rdata_q[1], rdata_q[0]};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [DW-1:0] data; int due; } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  task automatic push(input int c, input logic [DW-1:0] d, input int due);
    rsp_t r;
    r.data = d;
    r.due  = due;
    if (c == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Monitor: every presented response must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_rsp_valid[c]) begin
          rsp_t r;
          if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected_ch%0d: got rdata %0h expected no response (cycle %0d)",
                     c, ch_rsp_rdata[c*DW +: DW], cyc);
          end else begin
            r = (c == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rsp_data_ch%0d", c), 64'(ch_rsp_rdata[c*DW +: DW]), 64'(r.data));
            chk($sformatf("rsp_cycle_ch%0d", c), 64'(cyc), 64'(r.due));
          end
        end
      end
    end
  end

  task automatic drive(input int c, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_req_valid[c]         = v;
    ch_req_wr[c]            = w;
    ch_req_addr[c*AW +: AW] = a;
    ch_req_wdata[c*DW +: DW] = d;
  endtask

  task automatic idle_all();
    ch_req_valid = '0;
    ch_req_wr    = '0;
    ch_req_addr  = '0;
    ch_req_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] exp_rdy [4];

  initial begin
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    repeat (3) next_cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 64'(ch_rsp_valid), 64'h0);
    chk("rst_rsp_rdata", 64'(ch_rsp_rdata[DW-1:0]), 64'h0);
    chk("rst_conflict", 64'(conflict_cnt), 64'h0);
    chk("rst_bank_en", 64'(bank_en), 64'h0);

    // Single read: addr 0x0024 -> bank 1, row 2
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0024, '0);
    @(negedge clk);
    chk("t1_ready", 64'(ch_req_ready), 64'h1);
    chk("t1_bank_en", 64'(bank_en), 64'h2);
    chk("t1_bank_wen", 64'(bank_wen), 64'h0);
    chk("t1_bank_addr1", 64'(bank_addr[1*RW +: RW]), 64'h002);
    chk("t1_bank_addr0_idle", 64'(bank_addr[0 +: RW]), 64'h0);
    push(0, 39'h12345, cyc + LAT);
    next_cycle();
    idle_all();

    // Parallel banks: ch0 read bank 0 row 4, ch1 write bank 3 row 8
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0040, '0);
    drive(1, 1'b1, 1'b1, 16'h008C, 39'h55);
    @(negedge clk);
    chk("t2_ready", 64'(ch_req_ready), 64'h3);
    chk("t2_bank_en", 64'(bank_en), 64'h9);
    chk("t2_bank_wen", 64'(bank_wen), 64'h8);
    chk("t2_bank_addr0", 64'(bank_addr[0 +: RW]), 64'h004);
    chk("t2_bank_addr3", 64'(bank_addr[3*RW +: RW]), 64'h008);
    chk("t2_bank_wdata3", 64'(bank_wdata[3*DW +: DW]), 64'h55);
    push(0, 39'h0AAAA, cyc + LAT);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("t2_conflict", 64'(conflict_cnt), 64'h0);

    // Same-bank conflict on bank 2 for 4 cycles
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0008, '0);
    drive(1, 1'b1, 1'b0, 16'h0018, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_ready_%0d", k), 64'(ch_req_ready), 64'(exp_rdy[k]));
      if (k % 2 == 0) push(0, 39'h00100, cyc + LAT);
      else            push(1, 39'h00201, cyc + LAT);
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    chk("t3_conflict", 64'(conflict_cnt), 64'h4);

    // Write then read the same address through the SRAM model
    next_cycle();
    drive(0, 1'b1, 1'b1, 16'h0100, 39'h7F0);
    @(negedge clk);
    chk("t4_wr_ready", 64'(ch_req_ready), 64'h1);
    chk("t4_wr_wen", 64'(bank_wen), 64'h1);
    chk("t4_wr_addr", 64'(bank_addr[0 +: RW]), 64'h010);
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0100, '0);
    @(negedge clk);
    chk("t4_rd_ready", 64'(ch_req_ready), 64'h1);
    push(0, 39'h7F0, cyc + LAT);
    next_cycle();
    idle_all();

    // Reset mid-read: ch0 wins bank 2 alone (pointer moves to 1), then reset
    next_cycle();
    drive(0, 1'b1, 1'b0, 16'h0008, '0);
    @(negedge clk);
    chk("t5_ready", 64'(ch_req_ready), 64'h1);
    next_cycle();
    idle_all();
    rst = 1'b1;
    #1;
    chk("t5_rst_rsp_valid", 64'(ch_rsp_valid), 64'h0);
    chk("t5_rst_rsp_rdata", 64'(ch_rsp_rdata[DW-1:0]), 64'h0);
    chk("t5_rst_conflict", 64'(conflict_cnt), 64'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_post_rsp_valid_%0d", k), 64'(ch_rsp_valid), 64'h0);
      next_cycle();
    end
    drive(0, 1'b1, 1'b0, 16'h0008, '0);
    drive(1, 1'b1, 1'b0, 16'h0018, '0);
    @(negedge clk);
    chk("t5_rr_reset_ready", 64'(ch_req_ready), 64'h1);
    push(0, 39'h00100, cyc + LAT);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("t5_conflict", 64'(conflict_cnt), 64'h1);

    // Saturation: both channels write bank 2, one loser per cycle
    next_cycle();
    drive(0, 1'b1, 1'b1, 16'h0008, '0);
    drive(1, 1'b1, 1'b1, 16'h0018, '0);
    @(negedge clk);
    chk("t6_first_ready", 64'(ch_req_ready), 64'h2);
    repeat (65533) @(posedge clk);
    @(negedge clk);
    chk("t6_conflict_fffe", 64'(conflict_cnt), 64'hFFFE);
    repeat (70000 - 65533) @(posedge clk);
    @(negedge clk);
    chk("t6_conflict_sat", 64'(conflict_cnt), 64'hFFFF);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("t6_conflict_hold", 64'(conflict_cnt), 64'hFFFF);

    repeat (4) next_cycle();
    chk("q0_drained", 64'(q0.size()), 64'h0);
    chk("q1_drained", 64'(q1.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
